// File: rtl/conv_pkg.sv
// Shared encodings and helpers for the 3x3 convolution engine.
// Used by the coefficient bank and the datapath.
package conv_pkg;

  localparam int NUM_TAPS   = 9;
  localparam int CENTRE_TAP = 4;

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_BOX    = 2'd1;
  localparam logic [1:0] MODE_CUSTOM = 2'd2;
  localparam logic [1:0] MODE_ABS    = 2'd3;

  // One bit per tap: which taps hold coefficient 1 after reset.
  localparam logic [NUM_TAPS-1:0] IDENTITY_MASK = 9'b0_0001_0000;

  function automatic logic signed [31:0] sat_pix(
    input logic signed [31:0] v,
    input int                 w
  );
    logic signed [31:0] top;
    top = (32'sd1 <<< w) - 32'sd1;
    if (v < 0)
      return '0;
    if (v > top)
      return top;
    return v;
  endfunction

endpackage

// File: rtl/conv_coef_bank.sv
// Shadow/active coefficient registers with deferred commit.
// A commit only copies on a cycle without an incoming window.
module conv_coef_bank
  import conv_pkg::*;
#(
  parameter int COEF_W = 8
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       coef_wr_en_in,
  input  logic [3:0]                 coef_addr_in,
  input  logic [COEF_W-1:0]          coef_data_in,
  input  logic                       coef_commit_in,
  input  logic                       pixel_data_valid_in,
  output logic [NUM_TAPS*COEF_W-1:0] coef_active,
  output logic                       commit_pending_out
);

  logic [COEF_W-1:0] shadow_q [NUM_TAPS];
  logic [COEF_W-1:0] shadow_d [NUM_TAPS];
  logic [COEF_W-1:0] active_q [NUM_TAPS];
  logic              pending_q;
  logic              commit_req;
  logic              copy_now;

  assign commit_req         = coef_commit_in | pending_q;
  assign copy_now           = commit_req & ~pixel_data_valid_in;
  assign commit_pending_out = pending_q;

  // Same-cycle write is visible to a same-cycle copy.
  always_comb begin
    for (int i = 0; i < NUM_TAPS; i++) begin
      shadow_d[i] = shadow_q[i];
      if (coef_wr_en_in && coef_addr_in == 4'(i))
        shadow_d[i] = coef_data_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pending_q <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        shadow_q[i] <= {{(COEF_W-1){1'b0}}, IDENTITY_MASK[i]};
        active_q[i] <= {{(COEF_W-1){1'b0}}, IDENTITY_MASK[i]};
      end
    end else begin
      pending_q <= commit_req & pixel_data_valid_in;
      for (int i = 0; i < NUM_TAPS; i++) begin
        shadow_q[i] <= shadow_d[i];
        if (copy_now)
          active_q[i] <= shadow_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_TAPS; g++) begin : g_flat
    assign coef_active[g*COEF_W +: COEF_W] = active_q[g];
  end

endmodule

// File: rtl/conv3x3_kernel_engine.sv
// Three-stage 3x3 convolution: multiply, sum, normalise/saturate.
// One window in, one pixel out per cycle, no stall.
module conv3x3_kernel_engine
  import conv_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int COEF_W  = 8,
  parameter int ACC_W   = PIX_W + COEF_W + 4,
  parameter int SHIFT_W = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [NUM_TAPS*PIX_W-1:0] pixel_data_in,
  input  logic                      pixel_data_valid_in,
  input  logic [1:0]                mode_in,
  input  logic [SHIFT_W-1:0]        norm_shift_in,
  input  logic                      coef_wr_en_in,
  input  logic [3:0]                coef_addr_in,
  input  logic [COEF_W-1:0]         coef_data_in,
  input  logic                      coef_commit_in,
  output logic [PIX_W-1:0]          pixel_conv_out,
  output logic                      pixel_conv_valid_out,
  output logic                      commit_pending_out
);

  // Nine full-scale pixels fit in PIX_W+4 bits.
  localparam int BOX_W = PIX_W + 4;
  localparam logic [BOX_W-1:0] NINE = BOX_W'(9);

  logic [NUM_TAPS*COEF_W-1:0] coef_active;

  logic                    v1, v2;
  logic signed [ACC_W-1:0] prod_d [NUM_TAPS];
  logic signed [ACC_W-1:0] prod_q [NUM_TAPS];
  logic [BOX_W-1:0]        raw_d, raw1, raw2;
  logic [1:0]              mode1, mode2;
  logic [SHIFT_W-1:0]      sh1, sh2;
  logic [PIX_W-1:0]        ctr1, ctr2;
  logic signed [ACC_W-1:0] acc_d, acc2;
  logic signed [ACC_W-1:0] shr;
  logic [ACC_W-1:0]        mag;
  logic [PIX_W-1:0]        pix_d;

  conv_coef_bank #(
    .COEF_W (COEF_W)
  ) u_bank (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .coef_wr_en_in       (coef_wr_en_in),
    .coef_addr_in        (coef_addr_in),
    .coef_data_in        (coef_data_in),
    .coef_commit_in      (coef_commit_in),
    .pixel_data_valid_in (pixel_data_valid_in),
    .coef_active         (coef_active),
    .commit_pending_out  (commit_pending_out)
  );

  always_comb begin
    raw_d = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      prod_d[i] =
        ACC_W'($signed({1'b0, pixel_data_in[i*PIX_W +: PIX_W]}))
        * ACC_W'($signed(coef_active[i*COEF_W +: COEF_W]));
      raw_d = raw_d + BOX_W'(pixel_data_in[i*PIX_W +: PIX_W]);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      v1    <= 1'b0;
      raw1  <= '0;
      mode1 <= MODE_PASS;
      sh1   <= '0;
      ctr1  <= '0;
      for (int i = 0; i < NUM_TAPS; i++)
        prod_q[i] <= '0;
    end else begin
      v1 <= pixel_data_valid_in;
      if (pixel_data_valid_in) begin
        raw1  <= raw_d;
        mode1 <= mode_in;
        sh1   <= norm_shift_in;
        ctr1  <= pixel_data_in[CENTRE_TAP*PIX_W +: PIX_W];
        for (int i = 0; i < NUM_TAPS; i++)
          prod_q[i] <= prod_d[i];
      end
    end
  end

  always_comb begin
    acc_d = '0;
    for (int i = 0; i < NUM_TAPS; i++)
      acc_d = acc_d + prod_q[i];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      v2    <= 1'b0;
      acc2  <= '0;
      raw2  <= '0;
      mode2 <= MODE_PASS;
      sh2   <= '0;
      ctr2  <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        acc2  <= acc_d;
        raw2  <= raw1;
        mode2 <= mode1;
        sh2   <= sh1;
        ctr2  <= ctr1;
      end
    end
  end

  always_comb begin
    shr   = acc2 >>> sh2;
    mag   = acc2[ACC_W-1] ? $unsigned(-acc2) : $unsigned(acc2);
    mag   = mag >> sh2;
    pix_d = ctr2;
    unique case (mode2)
      MODE_PASS:
        pix_d = ctr2;
      MODE_BOX:
        pix_d = PIX_W'(sat_pix(32'(raw2 / NINE), PIX_W));
      MODE_CUSTOM:
        pix_d = PIX_W'(sat_pix(32'(shr), PIX_W));
      MODE_ABS:
        pix_d = PIX_W'(sat_pix(32'(mag), PIX_W));
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pixel_conv_valid_out <= 1'b0;
      pixel_conv_out       <= '0;
    end else begin
      pixel_conv_valid_out <= v2;
      if (v2)
        pixel_conv_out <= pix_d;
    end
  end

endmodule

// File: tb/tb_conv3x3_kernel_engine.sv
// Scoreboard bench for conv3x3_kernel_engine.
// Directed plan items followed by a randomised run.
module tb_conv3x3_kernel_engine;

  localparam int PW = 8;
  localparam int CW = 8;
  localparam int SW = 4;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [9*PW-1:0] pixel_data_in = '0;
  logic          pixel_data_valid_in = 1'b0;
  logic [1:0]    mode_in = '0;
  logic [SW-1:0] norm_shift_in = '0;
  logic          coef_wr_en_in = 1'b0;
  logic [3:0]    coef_addr_in = '0;
  logic [CW-1:0] coef_data_in = '0;
  logic          coef_commit_in = 1'b0;
  logic [PW-1:0] pixel_conv_out;
  logic          pixel_conv_valid_out;
  logic          commit_pending_out;

  always #5 clk_in = ~clk_in;

  conv3x3_kernel_engine #(
    .PIX_W   (PW),
    .COEF_W  (CW),
    .SHIFT_W (SW)
  ) dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .pixel_data_in        (pixel_data_in),
    .pixel_data_valid_in  (pixel_data_valid_in),
    .mode_in              (mode_in),
    .norm_shift_in        (norm_shift_in),
    .coef_wr_en_in        (coef_wr_en_in),
    .coef_addr_in         (coef_addr_in),
    .coef_data_in         (coef_data_in),
    .coef_commit_in       (coef_commit_in),
    .pixel_conv_out       (pixel_conv_out),
    .pixel_conv_valid_out (pixel_conv_valid_out),
    .commit_pending_out   (commit_pending_out)
  );

  typedef struct {
    int pix;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   act[9];
  int   shd[9];
  bit   pend = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic int clamp(int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic int ref_pix(logic [71:0] w, logic [1:0] m, int sh);
    int s, raw, p;
    s = 0;
    raw = 0;
    for (int i = 0; i < 9; i++) begin
      p = int'(w[i*8 +: 8]);
      raw += p;
      s += p * act[i];
    end
    case (m)
      2'd0: return int'(w[32 +: 8]);
      2'd1: return raw / 9;
      2'd2: return clamp(s >>> sh);
      default: begin
        if (s < 0) s = -s;
        return clamp(s >> sh);
      end
    endcase
  endfunction

  function automatic logic [71:0] fill(int c, int o);
    logic [71:0] w;
    for (int i = 0; i < 9; i++)
      w[i*8 +: 8] = (i == 4) ? 8'(c) : 8'(o);
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin
      act[i] = (i == 4) ? 1 : 0;
      shd[i] = act[i];
    end
    pend = 1'b0;
  endtask

  task automatic step(input bit v, input logic [71:0] w,
                      input logic [1:0] m, input logic [3:0] sh,
                      input bit we, input logic [3:0] a,
                      input logic [7:0] d, input bit cm);
    exp_t e;
    @(negedge clk_in);
    n_chk++;
    if (commit_pending_out !== pend) begin
      n_fail++;
      $display("FAIL commit_pending got=%0b want=%0b cyc=%0d",
               commit_pending_out, pend, cyc);
    end
    pixel_data_valid_in = v;
    pixel_data_in       = w;
    mode_in             = m;
    norm_shift_in       = sh;
    coef_wr_en_in       = we;
    coef_addr_in        = a;
    coef_data_in        = d;
    coef_commit_in      = cm;
    if (v) begin
      e.pix = ref_pix(w, m, int'(sh));
      e.cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk_in);
    if (we && a < 4'd9) shd[a] = int'($signed(d));
    if (cm || pend) begin
      if (!v) begin
        act  = shd;
        pend = 1'b0;
      end else begin
        pend = 1'b1;
      end
    end
  endtask

  task automatic win(input logic [71:0] w, input logic [1:0] m,
                     input logic [3:0] sh);
    step(1'b1, w, m, sh, 1'b0, 4'd0, 8'd0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, '0, 2'd0, 4'd0, 1'b0, 4'd0, 8'd0, 1'b0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d,
                    input bit cm);
    step(1'b0, '0, 2'd0, 4'd0, 1'b1, a, d, cm);
  endtask

  // Monitor: pops the scoreboard on every presented output.
  always @(negedge clk_in) begin
    if (pixel_conv_valid_out) begin
      exp_t e;
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output got=%0d cyc=%0d",
                 pixel_conv_out, cyc);
      end else begin
        e = sb.pop_front();
        if (int'(pixel_conv_out) != e.pix || cyc - e.cyc != 3) begin
          n_fail++;
          $display("FAIL pixel got=%0d want=%0d latency=%0d want=3",
                   pixel_conv_out, e.pix, cyc - e.cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [71:0] w;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    n_chk++;
    if (pixel_conv_out !== '0 || pixel_conv_valid_out !== 1'b0
        || commit_pending_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got=%0d/%0b/%0b want=0/0/0",
               pixel_conv_out, pixel_conv_valid_out, commit_pending_out);
    end
    @(negedge clk_in);
    rst_in = 1'b0;

    // Box blur.
    win(fill(90, 90), 2'd1, 4'd0);
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'(i);
    win(w, 2'd1, 4'd0);
    win(fill(255, 255), 2'd1, 4'd0);
    // Pass-through and identity custom.
    win(fill(77, 200), 2'd0, 4'd0);
    win(fill(77, 200), 2'd2, 4'd0);
    idle();

    // Laplacian, committed while idle.
    for (int i = 0; i < 9; i++)
      wr(4'(i), (i == 4) ? 8'd8 : 8'hFF, 1'b0);
    wr(4'd0, 8'hFF, 1'b1);
    win(fill(100, 10), 2'd2, 4'd0);
    win(fill(10, 100), 2'd2, 4'd0);
    win(fill(10, 100), 2'd3, 4'd3);

    // Commit during a burst of four windows.
    wr(4'd0, 8'd2, 1'b0);
    step(1'b1, fill(50, 20), 2'd2, 4'd0, 1'b0, 4'd0, 8'd0, 1'b1);
    step(1'b1, fill(60, 5), 2'd2, 4'd0, 1'b0, 4'd0, 8'd0, 1'b1);
    win(fill(30, 3), 2'd3, 4'd1);
    win(fill(40, 4), 2'd2, 4'd0);
    idle();
    win(fill(40, 4), 2'd2, 4'd0);

    // Out-of-range write, then write and commit together.
    wr(4'd12, 8'd5, 1'b1);
    win(fill(40, 4), 2'd2, 4'd0);
    wr(4'd4, 8'd3, 1'b1);
    win(fill(40, 4), 2'd2, 4'd0);
    idle();

    // Randomised traffic.
    for (int n = 0; n < 300; n++) begin
      bit v, we, cm;
      for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) w = fill(255, 255);
      if ($urandom_range(0, 7) == 0) w = '0;
      v  = ($urandom_range(0, 9) < 7);
      we = ($urandom_range(0, 3) == 0);
      cm = ($urandom_range(0, 9) == 0);
      step(v, w, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           we, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), cm);
    end
    repeat (2) idle();

    // Load a kernel, then reset with windows in flight.
    wr(4'd0, 8'd7, 1'b1);
    win(fill(11, 22), 2'd2, 4'd0);
    win(fill(33, 44), 2'd2, 4'd0);
    win(fill(55, 66), 2'd2, 4'd0);
    #2;
    rst_in              = 1'b1;
    pixel_data_valid_in = 1'b0;
    coef_wr_en_in       = 1'b0;
    coef_commit_in      = 1'b0;
    #1;
    n_chk++;
    if (pixel_conv_valid_out !== 1'b0 || pixel_conv_out !== '0) begin
      n_fail++;
      $display("FAIL async_reset got=%0b/%0d want=0/0",
               pixel_conv_valid_out, pixel_conv_out);
    end
    sb.delete();
    model_reset();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (4) idle();
    win(fill(123, 45), 2'd2, 4'd0);
    win(fill(123, 45), 2'd3, 4'd0);
    repeat (5) idle();

    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv3x3_kernel_engine.md
Name: conv3x3_kernel_engine

Overview:
Parametrised 3x3 convolution engine for the zoom/filter datapath. It consumes one 3x3 window per cycle from the line-buffer stage and produces one filtered pixel with a fixed pipeline latency. Kernel behaviour is selectable at run time: pass-through, box blur, signed custom kernel, or absolute-value custom kernel for edge detection. Custom coefficients load through a write port into a shadow bank and take effect only on an explicit commit, so a frame never mixes kernels.

Parameters:
PIX_W, 8, pixel width in bits (unsigned)
COEF_W, 8, coefficient width in bits (two's complement signed)
ACC_W, PIX_W+COEF_W+4, signed accumulator width; must hold 9 worst-case products without overflow
SHIFT_W, 4, width of the normalisation shift field

Ports:
clk_in  in  1  system clock, rising edge
rst_in  in  1  asynchronous active-high reset
pixel_data_in  in  9*PIX_W  window; tap i at [i*PIX_W +: PIX_W], i=0..8 raster order, i=4 centre
pixel_data_valid_in  in  1  window valid this cycle
mode_in  in  2  0 pass-through, 1 box blur, 2 signed custom, 3 abs custom; sampled with each valid window
norm_shift_in  in  SHIFT_W  arithmetic right shift applied in modes 2/3; sampled with each valid window
coef_wr_en_in  in  1  write one shadow coefficient
coef_addr_in  in  4  shadow index 0..8; values 9..15 ignored
coef_data_in  in  COEF_W  signed coefficient value
coef_commit_in  in  1  copy shadow bank to active bank
pixel_conv_out  out  PIX_W  filtered pixel
pixel_conv_valid_out  out  1  pixel_conv_out valid
commit_pending_out  out  1  high from commit request until the active bank is updated

Behaviour:
- Reset: pixel_conv_out=0, pixel_conv_valid_out=0, commit_pending_out=0; all pipeline valids cleared. Shadow and active coefficients reset to identity: tap 4=1, all others 0. Reset mid-operation discards in-flight pixels with no partial outputs.
- Pipeline, fixed latency 3: a window valid at edge N produces its output valid at edge N+3. There is no stall. Valid propagates through a 3-deep shift register alongside the data.
- Stage 1 registers the nine signed products of (zero-extended pixel × active coefficient), plus mode, shift and the centre pixel.
- Stage 2 registers the ACC_W signed sum of all nine products. Every tap contributes, including index 0.
- Stage 3 normalises, saturates and registers the output:
  - mode 0: output = centre pixel, unchanged.
  - mode 1: output = floor(sum of the 9 raw pixels / 9), exact for every input; the coefficient bank is ignored. Any implementation method is acceptable, including reciprocal multiply, as long as the result is bit-exact.
  - mode 2: s = sum >>> norm_shift (arithmetic shift); clamp to [0, 2^PIX_W-1].
  - mode 3: s = |sum| >> norm_shift; clamp to 2^PIX_W-1.
- Mode and shift travel with their window, so changing them between windows never corrupts an in-flight pixel.
- Coefficient writes:
  - coef_wr_en_in writes only the shadow bank.
  - A write with addr>8 is a no-op.
  - A write and a commit in the same cycle: the write lands in shadow first, and the committed bank includes it.
- Commit handling:
  - A commit pulse with pixel_data_valid_in low: the active bank updates at that edge; commit_pending_out stays 0.
  - A commit with pixel_data_valid_in high: the request is held, commit_pending_out=1, and the copy happens on the first edge where pixel_data_valid_in is low. That edge is the blanking boundary.
  - Writes while pending still update shadow and are included in the copy.
  - Repeated commit pulses while pending are absorbed into the single pending request.
- Windows sampled in stage 1 always use the active bank present at their sampling edge.

Decomposition:
- Shared package conv_pkg:
  - mode encodings MODE_PASS/MODE_BOX/MODE_CUSTOM/MODE_ABS;
  - NUM_TAPS=9 and CENTRE_TAP=4;
  - identity-kernel reset constant;
  - a saturate-to-PIX_W function.
- One natural sub-module: conv_coef_bank. It holds the shadow/active registers, write decode, pending commit logic and commit_pending_out, and presents a flat 9*COEF_W active vector to the datapath.

Test Plan:
- Reset then mode 1, all taps 90 -> output 90 three cycles after valid; taps 0..8 = 0,1,...,8 (sum 36) -> 4; all 255 -> 255.
- Mode 0 with reset (identity) bank, centre 77, others 200 -> 77. Mode 2 with identity bank, shift 0, same window -> 77.
- Load Laplacian (centre 8, others -1), commit while idle; mode 2, shift 0:
  - centre 100, others 10 -> 255 (720 saturated);
  - centre 10, others 100 -> 0 (negative clamp);
  - mode 3, same window, shift 3 -> 90 (|−720|>>3).
- Commit asserted during a valid burst of 4 windows -> commit_pending_out=1 for the burst, bank switches on the first idle edge, and all 4 outputs use the old kernel.
- Write addr 12 -> no change. Write and commit in the same idle cycle -> the new coefficient is effective on the next window.
- Assert rst_in asynchronously with 2 windows in flight -> pixel_conv_valid_out drops immediately, no stale output after release, and the bank returns to identity.
